// File: rtl/uart_hamming_pkg.sv
// Shared constants, FSM encoding and syndrome helper for the UART Hamming(12,8) link.
// The transmitter/encoder side uses the same parity and data position tables.
package uart_hamming_pkg;

  localparam int unsigned CLK_HZ           = 100_000_000;
  localparam int unsigned BIT_RATE         = 115_200;
  localparam int unsigned DEF_CLKS_PER_BIT = CLK_HZ / BIT_RATE;

  localparam int unsigned CW_W     = 12;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SYN_W    = 4;
  localparam int unsigned N_PARITY = 4;

  localparam int unsigned PARITY_POS [N_PARITY] = '{1, 2, 4, 8};
  localparam int unsigned DATA_POS   [DATA_W]   = '{3, 5, 6, 7, 9, 10, 11, 12};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DECODE
  } rx_state_e;

  // Syndrome bit k is the even-parity check over every position whose index has bit k set.
  function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CW_W:1] cw);
    logic [SYN_W-1:0] syn;
    syn = '0;
    for (int unsigned k = 0; k < N_PARITY; k++) begin
      for (int unsigned p = 1; p <= CW_W; p++) begin
        if ((p & PARITY_POS[k]) != 0) syn[k] = syn[k] ^ cw[p];
      end
    end
    return syn;
  endfunction

endpackage

// File: rtl/hamming12_8_dec.sv
// Combinational Hamming(12,8) single-error-correcting decoder.
// Syndromes 13..15 point outside the codeword and are reported as uncorrectable.
module hamming12_8_dec
  import uart_hamming_pkg::*;
(
  input  logic [CW_W:1]     cw_i,
  output logic [DATA_W-1:0] data_o,
  output logic [SYN_W-1:0]  syndrome_o,
  output logic              corrected_o,
  output logic              uncorrectable_o
);

  logic [CW_W:1] fixed;

  always_comb begin
    syndrome_o      = hamming_syndrome(cw_i);
    corrected_o     = (syndrome_o != '0) && (syndrome_o <= SYN_W'(CW_W));
    uncorrectable_o = (syndrome_o > SYN_W'(CW_W));

    fixed = cw_i;
    for (int unsigned p = 1; p <= CW_W; p++) begin
      if (corrected_o && (syndrome_o == SYN_W'(p))) fixed[p] = ~cw_i[p];
    end

    data_o = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      data_o[i] = fixed[DATA_POS[i]];
    end
  end

endmodule

// File: rtl/uart_rx_hamming_dec.sv
// UART receiver for 14-bit frames (start, c1..c12, stop) with Hamming(12,8) decode.
// Result registers update on the edge leaving DECODE, together with a one-cycle valid.
module uart_rx_hamming_dec
  import uart_hamming_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] parallel_out,
  output logic       valid,
  output logic       err_corrected,
  output logic       err_uncorrectable,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    prev_q, prev_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              idx_q, idx_d;
  logic [CW_W:1]           cw_q, cw_d;
  logic                    stop_err_q, stop_err_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    corr_q, corr_d;
  logic                    unc_q, unc_d;
  logic                    ferr_q, ferr_d;
  logic                    valid_q, valid_d;

  logic                    line;
  logic [DATA_W-1:0]       dec_data;
  logic [SYN_W-1:0]        dec_syndrome;
  logic                    dec_corrected;
  logic                    dec_uncorrectable;
  logic                    unused_syndrome;

  assign line            = sync_q[SYNC_STAGES-1];
  assign unused_syndrome = ^dec_syndrome;

  hamming12_8_dec u_dec (
    .cw_i            (cw_q),
    .data_o          (dec_data),
    .syndrome_o      (dec_syndrome),
    .corrected_o     (dec_corrected),
    .uncorrectable_o (dec_uncorrectable)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      sync_q     <= '1;
      prev_q     <= 1'b1;
      cnt_q      <= '0;
      idx_q      <= '0;
      cw_q       <= '0;
      stop_err_q <= 1'b0;
      data_q     <= '0;
      corr_q     <= 1'b0;
      unc_q      <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      cw_q       <= cw_d;
      stop_err_q <= stop_err_d;
      data_q     <= data_d;
      corr_q     <= corr_d;
      unc_q      <= unc_d;
      ferr_q     <= ferr_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], serial_in};
    prev_d     = line;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    cw_d       = cw_q;
    stop_err_d = stop_err_q;
    data_d     = data_q;
    corr_d     = corr_q;
    unc_d      = unc_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (prev_q && !line) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!line) begin
            state_d = ST_DATA;
            idx_d   = 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // Shifting in from the top leaves c1 (sent first) at cw[1] after 12 samples.
          cw_d  = {line, cw_q[CW_W:2]};
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'(CW_W)) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          stop_err_d = ~line;
          state_d    = ST_DECODE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        data_d  = dec_data;
        corr_d  = dec_corrected;
        unc_d   = dec_uncorrectable;
        ferr_d  = stop_err_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign parallel_out      = data_q;
  assign valid             = valid_q;
  assign err_corrected     = corr_q;
  assign err_uncorrectable = unc_q;
  assign frame_err         = ferr_q;
  assign busy              = (state_q != ST_IDLE) || valid_q;

endmodule

// File: tb/tb_uart_rx_hamming_dec.sv
// Scoreboard bench for uart_rx_hamming_dec at a reduced bit period.
module tb_uart_rx_hamming_dec;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] parallel_out;
  logic       valid;
  logic       err_corrected;
  logic       err_uncorrectable;
  logic       frame_err;
  logic       busy;

  uart_rx_hamming_dec #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .serial_in         (serial_in),
    .parallel_out      (parallel_out),
    .valid             (valid),
    .err_corrected     (err_corrected),
    .err_uncorrectable (err_uncorrectable),
    .frame_err         (frame_err),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       corr;
    logic       unc;
    logic       ferr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int unsigned n_push = 0;
  int unsigned n_valid = 0;
  logic        prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:1] encode(input logic [7:0] d);
    logic [12:1] cw;
    logic        par;
    int          k;
    cw = '0;
    k  = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        k++;
      end
    end
    for (int b = 1; b <= 8; b = b * 2) begin
      par = 1'b0;
      for (int p = 1; p <= 12; p++) begin
        if (((p & b) != 0) && (p != b)) par = par ^ cw[p];
      end
      cw[b] = par;
    end
    return cw;
  endfunction

  function automatic exp_t model(input logic [12:1] cw_in, input logic stop_bit);
    exp_t        e;
    logic [12:1] cw;
    int          s;
    int          k;
    cw = cw_in;
    s  = 0;
    for (int p = 1; p <= 12; p++) if (cw[p]) s = s ^ p;
    e.corr = (s >= 1) && (s <= 12);
    e.unc  = (s >= 13);
    e.ferr = ~stop_bit;
    if (e.corr) cw[s] = ~cw[s];
    e.data = '0;
    k = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        e.data[k] = cw[p];
        k++;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      chk("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'd0, valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("data", {24'd0, parallel_out}, {24'd0, mon_e.data});
        chk("err_corrected", {31'd0, err_corrected}, {31'd0, mon_e.corr});
        chk("err_uncorrectable", {31'd0, err_uncorrectable}, {31'd0, mon_e.unc});
        chk("frame_err", {31'd0, frame_err}, {31'd0, mon_e.ferr});
      end
    end
    prev_valid = valid;
  end

  // rst_bit selects a frame bit (0=start .. 13=stop) at whose middle reset is pulsed; -1 for none.
  task automatic send_frame(input logic [12:1] cw, input logic stop_bit, input int rst_bit);
    logic [13:0] bits;
    bits = {stop_bit, cw, 1'b0};
    for (int b = 0; b < 14; b++) begin
      serial_in = bits[b];
      for (int c = 0; c < int'(CPB); c++) begin
        @(negedge clk);
        if (c == int'(CPB / 2)) begin
          if (b == rst_bit) begin
            reset     = 1'b0;
            serial_in = 1'b1;
            @(negedge clk);
            reset = 1'b1;
            chk("midrst_data", {24'd0, parallel_out}, 32'd0);
            chk("midrst_valid", {31'd0, valid}, 32'd0);
            chk("midrst_flags", {29'd0, err_corrected, err_uncorrectable, frame_err}, 32'd0);
            chk("midrst_busy", {31'd0, busy}, 32'd0);
            return;
          end
          chk("busy_in_frame", {31'd0, busy}, 32'd1);
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < int'(4 * CPB); i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic run_frame(input logic [12:1] cw, input logic stop_bit);
    exp_q.push_back(model(cw, stop_bit));
    n_push++;
    send_frame(cw, stop_bit, -1);
    serial_in = 1'b1;
    drain();
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:1] cw;
    logic [7:0]  d;

    reset     = 1'b0;
    serial_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_data", {24'd0, parallel_out}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_flags", {29'd0, err_corrected, err_uncorrectable, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    run_frame(12'hBF3, 1'b1);
    chk("hold_data", {24'd0, parallel_out}, 32'h0000_00BE);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    run_frame(12'hBE3, 1'b1);
    run_frame(12'hB73, 1'b1);
    run_frame(12'h3F2, 1'b1);

    for (int p = 1; p <= 12; p++) begin
      d     = 8'($urandom);
      cw    = encode(d);
      cw[p] = ~cw[p];
      run_frame(cw, 1'b1);
    end

    cw = encode(8'hC3);
    cw[6] = ~cw[6];
    cw[8] = ~cw[8];
    run_frame(cw, 1'b1);
    cw = encode(8'h81);
    cw[7] = ~cw[7];
    cw[8] = ~cw[8];
    run_frame(cw, 1'b1);

    for (int i = 0; i < 4; i++) run_frame(encode(8'($urandom)), 1'b1);
    run_frame(encode(8'h00), 1'b1);
    run_frame(encode(8'hFF), 1'b1);

    exp_q.push_back(model(12'hBF3, 1'b0));
    n_push++;
    send_frame(12'hBF3, 1'b0, -1);
    serial_in = 1'b0;
    drain();
    repeat (3 * CPB) @(negedge clk);
    chk("stuck_low_busy", {31'd0, busy}, 32'd0);
    serial_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    serial_in = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    serial_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_hold_ferr", {31'd0, frame_err}, 32'd1);

    send_frame(encode(8'h5A), 1'b1, 6);
    serial_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    run_frame(encode(8'h5A), 1'b1);
    chk("post_rst_data", {24'd0, parallel_out}, 32'h0000_005A);

    chk("valid_count", n_valid, n_push);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_rx_hamming_dec.md
Name: uart_rx_hamming_dec

Overview:
Receive half of the UART-with-Hamming link. It deserialises one frame from the serial line and Hamming(12,8) decodes the 12-bit codeword. The decoded byte is presented on parallel_out with a one-cycle valid strobe and error flags. It pairs with the existing UART transmitter/Hamming encoder in top, which drives serial_in from serial_out for loopback.

Parameters:
CLKS_PER_BIT, 868, system clocks per bit (100 MHz / 115200 baud); must be >= 4.
SYNC_STAGES, 2, flip-flops in the serial_in synchroniser.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous reset, active low.
serial_in  input  1  asynchronous serial line; idles high.
parallel_out  output  8  decoded/corrected data byte; held until the next frame.
valid  output  1  one-cycle pulse when parallel_out and the flags update.
err_corrected  output  1  qualified by valid: single-bit error corrected.
err_uncorrectable  output  1  qualified by valid: syndrome is 13..15, so data is the uncorrected extract.
frame_err  output  1  qualified by valid: stop bit was sampled low.
busy  output  1  high from start-bit detection until the valid cycle, inclusive.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on port reset; it is sampled only on the rising edge of clk.
- Reset (reset=0 at a clock edge): FSM goes to IDLE and counters clear. All outputs go to 0 (parallel_out=8'h00). The synchroniser is preset to 1.
- Reset mid-frame: abandon the frame, produce no valid pulse, and re-arm from IDLE.
- Frame format: start(0), then codeword bits c1..c12 with c1 first, then stop(1). Total 14 bit periods.
- Codeword layout: parity at positions 1, 2, 4 and 8.
  - Data positions: d0=c3, d1=c5, d2=c6, d3=c7, d4=c9, d5=c10, d6=c11, d7=c12.
  - Parity p_k covers every position whose index has bit k set. Parity is even.
- FSM states:
  - IDLE: wait for a falling edge on the synchronised line (previous sample 1, current 0). Then go to START and clear the baud counter.
  - START: count to CLKS_PER_BIT/2 (integer division). If the line is still 0, go to DATA with the counter cleared. If it is 1, treat it as a glitch and return to IDLE.
  - DATA: sample the line each time the counter reaches CLKS_PER_BIT-1, so sampling lands at mid-bit. Shift the sample into cw[idx], idx 1..12. After idx 12, go to STOP.
  - STOP: sample at mid-bit and record frame_err = ~sample. Go to DECODE.
  - DECODE: lasts exactly one cycle; see decode rules below. Return to IDLE.
- Decode rules, all evaluated in the DECODE cycle:
  - Syndrome s[3:0] = XOR of cw positions whose index has bit k set, for k = 0..3.
  - s==0: no error, both error flags 0.
  - s in 1..12: flip cw[s] and set err_corrected=1. This includes errors in parity bits.
  - s in 13..15: leave cw unflipped and set err_uncorrectable=1.
  - Double errors are not guaranteed to be detected; that is the SEC-only limit of the code.
  - In the same cycle, parallel_out and the flags register and valid=1.
- Latency: valid rises on the clock edge after the stop-bit mid-sample edge.
- After a frame error, IDLE still requires a 1→0 transition. A line stuck low therefore does not retrigger.
- Flags persist with parallel_out until the next valid. Consumers must qualify them with valid.
- Arithmetic: the baud counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 on each sample. idx is a 4-bit counter.
- Nominal frame duration at defaults: 14 × 868 = 12152 cycles, about 121.5 µs.

Decomposition:
- Shared package uart_hamming_pkg:
  - CLK_HZ=100000000, BIT_RATE=115200, derived CLKS_PER_BIT.
  - FSM state encoding: IDLE, START, DATA, STOP, DECODE.
  - Codeword width CW_W=12, data width 8.
  - Parity-position constants. The encoder must use the same constants.
- One natural sub-module: hamming12_8_dec. It is purely combinational: cw[12:1] → data[7:0], syndrome, corrected and uncorrectable.
- The FSM, baud counter and synchroniser stay in uart_rx_hamming_dec.

Test Plan:
- Benches may override CLKS_PER_BIT=16 for speed. Default-rate tests run at 100 MHz.
- Clean frame: send data 8'hBE as codeword cw[12:1]=12'hBF3 → one valid pulse, parallel_out=8'hBE, all flags 0, busy high for the whole frame.
- Single data-bit error: 12'hBF3 with c5 flipped (12'hBE3) → parallel_out=8'hBE, err_corrected=1, err_uncorrectable=0.
- Single parity-bit error: c8 flipped (12'hB73) → parallel_out=8'hBE, err_corrected=1.
- Frame error and glitch:
  - Valid codeword with stop=0 → valid pulse with frame_err=1 and data correct. No new frame is detected until the line returns high and then falls again.
  - A low pulse of CLKS_PER_BIT/4 cycles → no valid, and busy returns to 0.
- Reset mid-frame: assert reset=0 for 1 cycle during data bit 6 → all outputs go to 0 at the next edge and no valid pulse occurs. The following clean 8'h5A frame decodes correctly.
- Loopback with the transmitter in top: drive parallel_in=8'b10111110 with t_enable=1 and tie serial_out to serial_in → parallel_out=8'hBE with valid within 12200 cycles at default rate.
